// File: rtl/lattice_readout_if.sv
// lattice_readout_if: pixel stream handshake between the lattice readout and the display path.
// The readout drives pixel data and coordinates; the sink drives ready.
interface lattice_readout_if;
  logic       pixel_valid_out;
  logic       pixel_ready_in;
  logic [7:0] pixel_data_out;
  logic [7:0] pixel_x_out;
  logic [7:0] pixel_y_out;

  modport master (
    output pixel_valid_out,
    output pixel_data_out,
    output pixel_x_out,
    output pixel_y_out,
    input  pixel_ready_in
  );

  modport slave (
    input  pixel_valid_out,
    input  pixel_data_out,
    input  pixel_x_out,
    input  pixel_y_out,
    output pixel_ready_in
  );
endinterface

// File: rtl/lattice_readout.sv
// lattice_readout: raster readout of the LBM lattice BRAM into an 8-bit pixel stream.
// Credit-gated BRAM reads feed a compute stage that writes straight into a FWFT FIFO.
module lattice_readout #(
  parameter int BRAM_DEPTH   = 31570,
  parameter int GRID_WIDTH   = 205,
  parameter int BRAM_LATENCY = 2,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic                          start_in,
  input  logic [1:0]                    mode_in,
  input  logic [8:0][7:0]               bram_data_in,
  output logic [$clog2(BRAM_DEPTH)-1:0] addr_out,
  output logic                          busy_out,
  output logic                          done_out,
  lattice_readout_if.master             pix
);

  localparam int AW          = $clog2(BRAM_DEPTH);
  localparam int GRID_HEIGHT = BRAM_DEPTH / GRID_WIDTH;
  localparam int PW          = $clog2(FIFO_DEPTH);
  localparam int CW          = $clog2(FIFO_DEPTH + BRAM_LATENCY + 2) + 1;

  localparam logic [AW-1:0] LAST_ADDR = AW'(BRAM_DEPTH - 1);
  localparam logic [7:0]    LAST_X    = 8'(GRID_WIDTH - 1);
  localparam logic [7:0]    LAST_Y    = 8'(GRID_HEIGHT - 1);
  localparam logic [PW-1:0] LAST_PTR  = PW'(FIFO_DEPTH - 1);
  localparam logic [CW-1:0] FIFO_CAP  = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN
  } state_t;

  state_t                  state_q, state_d;
  logic [AW-1:0]           addr_q, addr_d;
  logic                    rd_v_q, rd_v_d;
  logic [BRAM_LATENCY-1:0] vsr_q, vsr_d;
  logic [1:0]              mode_q, mode_d;
  logic                    done_q, done_d;
  logic [7:0]              wx_q, wx_d;
  logic [7:0]              wy_q, wy_d;
  logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]           occ_q, occ_d;

  logic [7:0] mem_pix_q [FIFO_DEPTH];
  logic [7:0] mem_x_q   [FIFO_DEPTH];
  logic [7:0] mem_y_q   [FIFO_DEPTH];

  logic          start_ok;
  logic          push;
  logic          pop;
  logic          valid;
  logic          last_pop;
  logic          credit_ok;
  logic [CW-1:0] inflight;
  logic [7:0]    head_pix;
  logic [7:0]    head_x;
  logic [7:0]    head_y;
  logic [7:0]    pix_d;

  logic [11:0]        sum;
  logic [9:0]         pos;
  logic [9:0]         neg;
  logic signed [11:0] ux;
  logic signed [11:0] pv;

  assign valid    = (occ_q != '0);
  assign head_pix = mem_pix_q[rd_ptr_q];
  assign head_x   = mem_x_q[rd_ptr_q];
  assign head_y   = mem_y_q[rd_ptr_q];
  assign push     = vsr_q[BRAM_LATENCY-1];
  assign pop      = valid & pix.pixel_ready_in;
  assign last_pop = pop & (head_x == LAST_X) & (head_y == LAST_Y);
  assign start_ok = start_in & ~busy_out;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      rd_v_q   <= 1'b0;
      vsr_q    <= '0;
      mode_q   <= 2'b00;
      done_q   <= 1'b0;
      wx_q     <= '0;
      wy_q     <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      rd_v_q   <= rd_v_d;
      vsr_q    <= vsr_d;
      mode_q   <= mode_d;
      done_q   <= done_d;
      wx_q     <= wx_d;
      wy_q     <= wy_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  // Compute stage: the FIFO entry itself is the registered pixel result
  always_ff @(posedge clk_in) begin
    if (push) begin
      mem_pix_q[wr_ptr_q] <= pix_d;
      mem_x_q[wr_ptr_q]   <= wx_q;
      mem_y_q[wr_ptr_q]   <= wy_q;
    end
  end

  always_comb begin
    sum = '0;
    for (int i = 0; i < 9; i++) begin
      sum = sum + 12'(bram_data_in[i]);
    end
    pos = 10'(bram_data_in[2]) + 10'(bram_data_in[3])
        + 10'(bram_data_in[4]);
    neg = 10'(bram_data_in[6]) + 10'(bram_data_in[7])
        + 10'(bram_data_in[8]);
    ux  = $signed(12'(pos)) - $signed(12'(neg));
    pv  = 12'sd128 + (ux >>> 2);
    pix_d = '0;
    unique case (mode_q)
      2'b00:   pix_d = (sum > 12'd255) ? 8'hff : sum[7:0];
      2'b01:   pix_d = pv[11] ? 8'h00
                     : (pv > 12'sd255) ? 8'hff : pv[7:0];
      2'b10:   pix_d = bram_data_in[3];
      default: pix_d = bram_data_in[0];
    endcase
  end

  always_comb begin
    occ_d    = occ_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    wx_d     = wx_q;
    wy_d     = wy_q;
    if (push & ~pop) begin
      occ_d = occ_q + 1'b1;
    end else if (~push & pop) begin
      occ_d = occ_q - 1'b1;
    end
    if (push) begin
      wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
      if (wx_q == LAST_X) begin
        wx_d = '0;
        wy_d = wy_q + 1'b1;
      end else begin
        wx_d = wx_q + 1'b1;
      end
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
    end
    if (start_ok) begin
      wx_d = '0;
      wy_d = '0;
    end
  end

  // Reads still in the pipe after this edge must all find a FIFO slot
  always_comb begin
    vsr_d    = (vsr_q << 1) | BRAM_LATENCY'(rd_v_q);
    inflight = '0;
    for (int i = 0; i < BRAM_LATENCY; i++) begin
      inflight = inflight + CW'(vsr_d[i]);
    end
    credit_ok = (occ_d + inflight) < FIFO_CAP;
  end

  always_comb begin
    addr_d = addr_q;
    rd_v_d = 1'b0;
    mode_d = mode_q;
    done_d = (state_q == S_DRAIN) & last_pop;
    if (start_ok) begin
      addr_d = '0;
      rd_v_d = 1'b1;
      mode_d = mode_in;
    end else if ((state_q == S_ISSUE) && (addr_q != LAST_ADDR)
                 && credit_ok) begin
      addr_d = addr_q + 1'b1;
      rd_v_d = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start_ok) state_d = S_ISSUE;
      S_ISSUE: if (addr_q == LAST_ADDR) state_d = S_DRAIN;
      S_DRAIN: if (last_pop) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // done_q keeps the block busy for its pulse so a coincident start is dropped
  always_comb begin
    busy_out            = (state_q != S_IDLE) | done_q;
    done_out            = done_q;
    addr_out            = addr_q;
    pix.pixel_valid_out = valid;
    pix.pixel_data_out  = valid ? head_pix : '0;
    pix.pixel_x_out     = valid ? head_x : '0;
    pix.pixel_y_out     = valid ? head_y : '0;
  end

endmodule

// File: tb/tb_lattice_readout.sv
// tb_lattice_readout: scoreboard bench for the lattice readout on a reduced 12x5 grid.
// A two-stage BRAM model feeds the DUT; expected pixels are queued at frame start.
module tb_lattice_readout;
  localparam int DEPTH  = 60;
  localparam int WIDTH  = 12;
  localparam int LAT    = 2;
  localparam int FD     = 4;
  localparam int AW     = $clog2(DEPTH);
  localparam int BUDGET = 3000;

  typedef struct packed {
    logic [7:0] d;
    logic [7:0] x;
    logic [7:0] y;
  } pix_t;

  logic           clk = 1'b0;
  logic           rst_in = 1'b1;
  logic           start_in = 1'b0;
  logic [1:0]     mode_in = 2'b00;
  logic [8:0][7:0] bram_data_in = '0;
  logic [8:0][7:0] bram_d1 = '0;
  logic [AW-1:0]  addr_out;
  logic           busy_out;
  logic           done_out;
  logic [8:0][7:0] mem [DEPTH];

  pix_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   ready_mode = 0;
  bit   hold_chk = 0;
  pix_t hold_val;

  lattice_readout_if pix();

  lattice_readout #(
    .BRAM_DEPTH(DEPTH),
    .GRID_WIDTH(WIDTH),
    .BRAM_LATENCY(LAT),
    .FIFO_DEPTH(FD)
  ) dut (
    .clk_in(clk),
    .rst_in(rst_in),
    .start_in(start_in),
    .mode_in(mode_in),
    .bram_data_in(bram_data_in),
    .addr_out(addr_out),
    .busy_out(busy_out),
    .done_out(done_out),
    .pix(pix)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    bram_d1      <= (int'(addr_out) < DEPTH) ? mem[addr_out] : '0;
    bram_data_in <= bram_d1;
  end

  initial begin
    pix.pixel_ready_in = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       pix.pixel_ready_in = 1'b1;
        1:       pix.pixel_ready_in = 1'($urandom_range(0, 1));
        default: pix.pixel_ready_in = 1'b0;
      endcase
    end
  end

  // Scoreboard pop and hold-stability monitor
  always @(negedge clk) begin
    pix_t got;
    pix_t e;
    if (rst_in) begin
      hold_chk = 0;
    end else begin
      got = '{pix.pixel_data_out, pix.pixel_x_out, pix.pixel_y_out};
      if (hold_chk) begin
        tests++;
        if (pix.pixel_valid_out !== 1'b1 || got !== hold_val) begin
          fails++;
          $display("FAIL hold: valid=%b got d=%0d x=%0d y=%0d want d=%0d x=%0d y=%0d",
                   pix.pixel_valid_out, got.d, got.x, got.y,
                   hold_val.d, hold_val.x, hold_val.y);
        end
      end
      hold_chk = (pix.pixel_valid_out === 1'b1) && (pix.pixel_ready_in === 1'b0);
      hold_val = got;
      if (pix.pixel_valid_out === 1'b1 && pix.pixel_ready_in === 1'b1) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL extra_pixel: got d=%0d x=%0d y=%0d, want none",
                   got.d, got.x, got.y);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin
            fails++;
            $display("FAIL pixel: got d=%0d x=%0d y=%0d want d=%0d x=%0d y=%0d",
                     got.d, got.x, got.y, e.d, e.x, e.y);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] model(input logic [8:0][7:0] c,
                                       input logic [1:0] m);
    int s;
    int ux;
    int q;
    int p;
    s = 0;
    for (int i = 0; i < 9; i++) s += int'(c[i]);
    ux = (int'(c[2]) + int'(c[3]) + int'(c[4]))
       - (int'(c[6]) + int'(c[7]) + int'(c[8]));
    q = (ux >= 0) ? ux / 4 : -((3 - ux) / 4);
    case (m)
      2'b00:   p = (s > 255) ? 255 : s;
      2'b01:   p = 128 + q;
      2'b10:   p = int'(c[3]);
      default: p = int'(c[0]);
    endcase
    if (p < 0) p = 0;
    if (p > 255) p = 255;
    return 8'(p);
  endfunction

  task automatic push_frame(input logic [1:0] mode);
    pix_t e;
    for (int i = 0; i < DEPTH; i++) begin
      e.d = model(mem[i], mode);
      e.x = 8'(i % WIDTH);
      e.y = 8'(i / WIDTH);
      exp_q.push_back(e);
    end
  endtask

  task automatic fill_const(input logic [7:0] v);
    for (int i = 0; i < DEPTH; i++)
      for (int j = 0; j < 9; j++) mem[i][j] = v;
  endtask

  task automatic fill_random();
    for (int i = 0; i < DEPTH; i++)
      for (int j = 0; j < 9; j++) mem[i][j] = 8'($urandom);
  endtask

  task automatic do_frame(input logic [1:0] mode, input bit hold,
                          output int tv, output int td, output int nd);
    push_frame(mode);
    @(posedge clk);
    #1;
    start_in = 1'b1;
    mode_in  = mode;
    @(posedge clk);
    #1;
    mode_in = ~mode;
    if (!hold) start_in = 1'b0;
    tv = -1;
    td = -1;
    nd = 0;
    for (int n = 1; n <= BUDGET; n++) begin
      @(negedge clk);
      if (tv < 0 && pix.pixel_valid_out === 1'b1) tv = n;
      if (done_out === 1'b1) begin
        nd++;
        if (td < 0) td = n;
      end
      if (td >= 0 && n > td) break;
    end
    start_in = 1'b0;
  endtask

  task automatic test_reset();
    rst_in = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests++;
    if (addr_out !== '0 || pix.pixel_valid_out !== 1'b0 ||
        pix.pixel_data_out !== 8'd0 || pix.pixel_x_out !== 8'd0 ||
        pix.pixel_y_out !== 8'd0 || busy_out !== 1'b0 || done_out !== 1'b0) begin
      fails++;
      $display("FAIL reset_state: addr=%0d v=%b d=%0d x=%0d y=%0d busy=%b done=%b, want all 0",
               addr_out, pix.pixel_valid_out, pix.pixel_data_out,
               pix.pixel_x_out, pix.pixel_y_out, busy_out, done_out);
    end
    @(posedge clk);
    #1;
    rst_in = 1'b0;
  endtask

  task automatic test_density();
    int tv, td, nd;
    fill_const(8'd10);
    ready_mode = 0;
    do_frame(2'b00, 1'b1, tv, td, nd);
    tests++;
    if (tv !== LAT + 2) begin
      fails++;
      $display("FAIL density_latency: first valid %0d want %0d", tv, LAT + 2);
    end
    tests++;
    if (td !== DEPTH + LAT + 2) begin
      fails++;
      $display("FAIL density_done_cycle: got %0d want %0d", td, DEPTH + LAT + 2);
    end
    tests++;
    if (nd !== 1) begin
      fails++;
      $display("FAIL density_done_count: got %0d want 1", nd);
    end
    tests++;
    if (exp_q.size() !== 0) begin
      fails++;
      $display("FAIL density_missing: %0d pixels left, want 0", exp_q.size());
    end
    @(negedge clk);
    tests++;
    if (busy_out !== 1'b0 || done_out !== 1'b0) begin
      fails++;
      $display("FAIL density_idle: busy=%b done=%b want 0 0", busy_out, done_out);
    end
    exp_q.delete();
  endtask

  task automatic test_saturation();
    int tv, td, nd;
    fill_const(8'd255);
    for (int m = 0; m < 2; m++) begin
      do_frame((m == 0) ? 2'b00 : 2'b11, 1'b0, tv, td, nd);
      tests++;
      if (nd !== 1 || exp_q.size() !== 0) begin
        fails++;
        $display("FAIL saturation_frame%0d: done=%0d left=%0d want 1 0",
                 m, nd, exp_q.size());
      end
      exp_q.delete();
    end
  endtask

  task automatic test_velocity();
    int tv, td, nd;
    logic [7:0] v;
    for (int i = 0; i < DEPTH; i++) begin
      mem[i] = '0;
      v = 8'($urandom);
      case (i % 4)
        0: begin mem[i][2] = 8'd255; mem[i][3] = 8'd255; mem[i][4] = 8'd255; end
        1: begin mem[i][6] = 8'd255; mem[i][7] = 8'd255; mem[i][8] = 8'd255; end
        2: for (int j = 0; j < 9; j++) mem[i][j] = v;
        default: for (int j = 0; j < 9; j++) mem[i][j] = 8'($urandom);
      endcase
    end
    tests++;
    if (model(mem[0], 2'b01) !== 8'd255 || model(mem[1], 2'b01) !== 8'd0 ||
        model(mem[2], 2'b01) !== 8'd128) begin
      fails++;
      $display("FAIL velocity_model: e=%0d w=%0d eq=%0d want 255 0 128",
               model(mem[0], 2'b01), model(mem[1], 2'b01), model(mem[2], 2'b01));
    end
    do_frame(2'b01, 1'b0, tv, td, nd);
    tests++;
    if (nd !== 1 || exp_q.size() !== 0) begin
      fails++;
      $display("FAIL velocity_frame: done=%0d left=%0d want 1 0", nd, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_random_ready();
    int tv, td, nd;
    fill_random();
    for (int i = 0; i < DEPTH; i++) mem[i][0] = 8'(i);
    ready_mode = 1;
    do_frame(2'b11, 1'b0, tv, td, nd);
    ready_mode = 0;
    tests++;
    if (nd !== 1 || exp_q.size() !== 0) begin
      fails++;
      $display("FAIL random_ready_frame: done=%0d left=%0d want 1 0", nd, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_stall();
    int nd;
    bit seen;
    fill_random();
    ready_mode = 2;
    push_frame(2'b00);
    @(posedge clk);
    #1;
    start_in = 1'b1;
    mode_in  = 2'b00;
    @(posedge clk);
    #1;
    start_in = 1'b0;
    repeat (100) @(negedge clk);
    tests++;
    if (addr_out !== AW'(FD - 1) || pix.pixel_valid_out !== 1'b1 ||
        pix.pixel_x_out !== 8'd0 || pix.pixel_y_out !== 8'd0) begin
      fails++;
      $display("FAIL stall_state: addr=%0d v=%b x=%0d y=%0d want %0d 1 0 0",
               addr_out, pix.pixel_valid_out, pix.pixel_x_out,
               pix.pixel_y_out, FD - 1);
    end
    ready_mode = 0;
    nd = 0;
    seen = 0;
    for (int n = 0; n < BUDGET && !seen; n++) begin
      @(negedge clk);
      if (done_out === 1'b1) begin
        nd++;
        seen = 1;
      end
    end
    tests++;
    if (nd !== 1 || exp_q.size() !== 0) begin
      fails++;
      $display("FAIL stall_resume: done=%0d left=%0d want 1 0", nd, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_abort();
    int tv, td, nd, bad;
    fill_random();
    ready_mode = 0;
    push_frame(2'b00);
    @(posedge clk);
    #1;
    start_in = 1'b1;
    @(posedge clk);
    #1;
    start_in = 1'b0;
    repeat (20) @(negedge clk);
    @(posedge clk);
    #1;
    rst_in = 1'b1;
    @(posedge clk);
    #1;
    rst_in = 1'b0;
    exp_q.delete();
    @(negedge clk);
    tests++;
    if (addr_out !== '0 || pix.pixel_valid_out !== 1'b0 ||
        pix.pixel_data_out !== 8'd0 || busy_out !== 1'b0 || done_out !== 1'b0) begin
      fails++;
      $display("FAIL abort_reset: addr=%0d v=%b d=%0d busy=%b done=%b want all 0",
               addr_out, pix.pixel_valid_out, pix.pixel_data_out, busy_out, done_out);
    end
    bad = 0;
    repeat (6) begin
      @(negedge clk);
      if (pix.pixel_valid_out !== 1'b0) bad++;
    end
    tests++;
    if (bad !== 0) begin
      fails++;
      $display("FAIL abort_leak: %0d cycles with valid after reset, want 0", bad);
    end
    do_frame(2'b10, 1'b1, tv, td, nd);
    tests++;
    if (tv !== LAT + 2 || nd !== 1 || exp_q.size() !== 0) begin
      fails++;
      $display("FAIL abort_restart: first=%0d done=%0d left=%0d want %0d 1 0",
               tv, nd, exp_q.size(), LAT + 2);
    end
    @(negedge clk);
    tests++;
    if (busy_out !== 1'b0) begin
      fails++;
      $display("FAIL abort_idle: busy=%b want 0", busy_out);
    end
    exp_q.delete();
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    test_reset();
    test_density();
    test_saturation();
    test_velocity();
    test_random_ready();
    test_stall();
    test_abort();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
